control_seq: RTL and testbench

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq.sv | 169 ++++++++++++++++
 tb/tb_control_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
// Module   : control_seq
// Brief    : Microcode step sequencer for an 8-bit accumulator CPU; decodes a
//            one-hot T1..T5 step, opcode and flags into bus control strobes.
// Revision : 1.0 - initial release
// ============================================================================
module control_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flag_we,
    output logic       out_in,
    output logic       hlt,
    output logic [4:0] step
);

    typedef enum logic [4:0] {
        T1 = 5'b00001,
        T2 = 5'b00010,
        T3 = 5'b00100,
        T4 = 5'b01000,
        T5 = 5'b10000
    } step_t;

    localparam logic [3:0] c_OP_LDA = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_STA = 4'h4;
    localparam logic [3:0] c_OP_LDI = 4'h5;
    localparam logic [3:0] c_OP_JMP = 4'h6;
    localparam logic [3:0] c_OP_JC  = 4'h7;
    localparam logic [3:0] c_OP_JZ  = 4'h8;
    localparam logic [3:0] c_OP_OUT = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    step_t r_step;
    step_t w_step_next;
    logic  r_hlt;
    logic  w_hlt_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= T1;
            r_hlt  <= 1'b0;
        end else begin
            r_step <= w_step_next;
            if (w_hlt_set) begin
                r_hlt <= 1'b1;
            end
        end
    end

    // The default next step is T1, so every instruction ends early unless a
    // branch below explicitly extends it; this also freezes step while halted.
    always_comb begin
        w_step_next = T1;
        w_hlt_set   = 1'b0;
        pc_out      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        mar_in      = 1'b0;
        ram_in      = 1'b0;
        ram_out     = 1'b0;
        ir_in       = 1'b0;
        ir_out      = 1'b0;
        a_in        = 1'b0;
        a_out       = 1'b0;
        b_in        = 1'b0;
        alu_out     = 1'b0;
        alu_sub     = 1'b0;
        flag_we     = 1'b0;
        out_in      = 1'b0;

        if (!r_hlt) begin
            case (r_step)
                T1: begin
                    pc_out      = 1'b1;
                    mar_in      = 1'b1;
                    w_step_next = T2;
                end
                T2: begin
                    ram_out     = 1'b1;
                    ir_in       = 1'b1;
                    pc_inc      = 1'b1;
                    w_step_next = T3;
                end
                T3: begin
                    case (opcode)
                        c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                            ir_out      = 1'b1;
                            mar_in      = 1'b1;
                            w_step_next = T4;
                        end
                        c_OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        c_OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_load = 1'b1;
                        end
                        c_OP_JC: begin
                            ir_out  = cf;
                            pc_load = cf;
                        end
                        c_OP_JZ: begin
                            ir_out  = zf;
                            pc_load = zf;
                        end
                        c_OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        c_OP_HLT: w_hlt_set = 1'b1;
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        c_OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        c_OP_ADD, c_OP_SUB: begin
                            ram_out     = 1'b1;
                            b_in        = 1'b1;
                            w_step_next = T5;
                        end
                        c_OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
                        alu_out = 1'b1;
                        a_in    = 1'b1;
                        flag_we = 1'b1;
                        alu_sub = (opcode == c_OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign hlt  = r_hlt;
    assign step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_seq
// Brief    : Directed self-checking bench for control_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       cf;
    logic       zf;
    logic       pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out;
    logic       a_in, a_out, b_in, alu_out, alu_sub, flag_we, out_in, hlt;
    logic [4:0] step;
    logic [14:0] ctl;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [14:0] C_PC_OUT  = 15'h4000;
    localparam logic [14:0] C_PC_INC  = 15'h2000;
    localparam logic [14:0] C_PC_LOAD = 15'h1000;
    localparam logic [14:0] C_MAR_IN  = 15'h0800;
    localparam logic [14:0] C_RAM_IN  = 15'h0400;
    localparam logic [14:0] C_RAM_OUT = 15'h0200;
    localparam logic [14:0] C_IR_IN   = 15'h0100;
    localparam logic [14:0] C_IR_OUT  = 15'h0080;
    localparam logic [14:0] C_A_IN    = 15'h0040;
    localparam logic [14:0] C_A_OUT   = 15'h0020;
    localparam logic [14:0] C_B_IN    = 15'h0010;
    localparam logic [14:0] C_ALU_OUT = 15'h0008;
    localparam logic [14:0] C_ALU_SUB = 15'h0004;
    localparam logic [14:0] C_FLAG_WE = 15'h0002;
    localparam logic [14:0] C_OUT_IN  = 15'h0001;
    localparam logic [14:0] C_FETCH1  = C_PC_OUT | C_MAR_IN;
    localparam logic [14:0] C_FETCH2  = C_RAM_OUT | C_IR_IN | C_PC_INC;

    control_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .cf      (cf),
        .zf      (zf),
        .pc_out  (pc_out),
        .pc_inc  (pc_inc),
        .pc_load (pc_load),
        .mar_in  (mar_in),
        .ram_in  (ram_in),
        .ram_out (ram_out),
        .ir_in   (ir_in),
        .ir_out  (ir_out),
        .a_in    (a_in),
        .a_out   (a_out),
        .b_in    (b_in),
        .alu_out (alu_out),
        .alu_sub (alu_sub),
        .flag_we (flag_we),
        .out_in  (out_in),
        .hlt     (hlt),
        .step    (step)
    );

    assign ctl = {pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out,
                  a_in, a_out, b_in, alu_out, alu_sub, flag_we, out_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction table: opcode, cf, zf, cycle count, controls expected in T3..T5.
    localparam int N_INS = 13;
    logic [3:0]  tab_op  [N_INS] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h7,
                                     4'h8, 4'h8, 4'hE, 4'h0, 4'hA};
    logic        tab_cf  [N_INS] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                     1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        tab_zf  [N_INS] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                     1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          tab_len [N_INS] = '{4, 5, 5, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    logic [14:0] tab_t3  [N_INS] = '{C_IR_OUT | C_MAR_IN, C_IR_OUT | C_MAR_IN,
                                     C_IR_OUT | C_MAR_IN, C_IR_OUT | C_MAR_IN,
                                     C_IR_OUT | C_A_IN, C_IR_OUT | C_PC_LOAD,
                                     C_IR_OUT | C_PC_LOAD, 15'h0,
                                     C_IR_OUT | C_PC_LOAD, 15'h0,
                                     C_A_OUT | C_OUT_IN, 15'h0, 15'h0};
    logic [14:0] tab_t4  [N_INS] = '{C_RAM_OUT | C_A_IN, C_RAM_OUT | C_B_IN,
                                     C_RAM_OUT | C_B_IN, C_A_OUT | C_RAM_IN,
                                     15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0,
                                     15'h0, 15'h0, 15'h0};
    logic [14:0] tab_t5  [N_INS] = '{15'h0, C_ALU_OUT | C_A_IN | C_FLAG_WE,
                                     C_ALU_OUT | C_A_IN | C_FLAG_WE | C_ALU_SUB,
                                     15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0,
                                     15'h0, 15'h0, 15'h0, 15'h0};

    task automatic test_reset();
        rst_n  = 1'b0;
        opcode = 4'h0;
        cf     = 1'b0;
        zf     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (step !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_step: got %b want 00001", step);
        end
        n_tests++;
        if (hlt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hlt: got %b want 0", hlt);
        end
        n_tests++;
        if (ctl !== C_FETCH1) begin
            n_fail++;
            $display("FAIL reset_ctl: got %h want %h", ctl, C_FETCH1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entry point is the negedge inside T1; exit point is the negedge inside
    // the following T1. Opcode is scrambled during fetch to show it is ignored.
    task automatic test_instructions();
        logic [4:0]  exp_step;
        logic [14:0] exp_ctl;
        for (int i = 0; i < N_INS; i++) begin
            for (int k = 1; k <= tab_len[i] + 1; k++) begin
                if (k > 1) @(negedge clk);
                if (k <= 2) opcode = ~tab_op[i];
                else        opcode = tab_op[i];
                cf = (k == 3) ? tab_cf[i] : ~tab_cf[i];
                zf = (k == 3) ? tab_zf[i] : ~tab_zf[i];
                #1;
                case (k)
                    1:       begin exp_step = 5'b00001; exp_ctl = C_FETCH1;  end
                    2:       begin exp_step = 5'b00010; exp_ctl = C_FETCH2;  end
                    3:       begin exp_step = 5'b00100; exp_ctl = tab_t3[i]; end
                    4:       begin exp_step = 5'b01000; exp_ctl = tab_t4[i]; end
                    5:       begin exp_step = 5'b10000; exp_ctl = tab_t5[i]; end
                    default: begin exp_step = 5'b00001; exp_ctl = C_FETCH1;  end
                endcase
                if (k == tab_len[i] + 1) begin
                    exp_step = 5'b00001;
                    exp_ctl  = C_FETCH1;
                end
                n_tests++;
                if (step !== exp_step || ctl !== exp_ctl) begin
                    n_fail++;
                    $display("FAIL instr op=%h cf=%b zf=%b cyc=%0d: step %b ctl %h want step %b ctl %h",
                             tab_op[i], tab_cf[i], tab_zf[i], k, step, ctl, exp_step, exp_ctl);
                end
            end
        end
    endtask

    task automatic test_halt();
        opcode = 4'hF;
        cf     = 1'b0;
        zf     = 1'b0;
        #1;
        n_tests++;
        if (step !== 5'b00001 || hlt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_start: step %b hlt %b want 00001 0", step, hlt);
        end
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (step !== 5'b00100 || ctl !== 15'h0 || hlt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_t3: step %b ctl %h hlt %b want 00100 0000 0", step, ctl, hlt);
        end
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            opcode = 4'(c);
            cf     = c[0];
            zf     = c[1];
            #1;
            n_tests++;
            if (hlt !== 1'b1 || step !== 5'b00001 || ctl !== 15'h0) begin
                n_fail++;
                $display("FAIL halt_hold cyc=%0d: hlt %b step %b ctl %h want 1 00001 0000",
                         c, hlt, step, ctl);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (hlt !== 1'b0 || step !== 5'b00001 || ctl !== C_FETCH1) begin
            n_fail++;
            $display("FAIL halt_clear: hlt %b step %b ctl %h want 0 00001 %h",
                     hlt, step, ctl, C_FETCH1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        opcode = 4'h2;
        cf     = 1'b0;
        zf     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (step !== 5'b01000 || b_in !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: step %b b_in %b want 01000 1", step, b_in);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (step !== 5'b00001 || b_in !== 1'b0 || ctl !== C_FETCH1) begin
            n_fail++;
            $display("FAIL mid_async: step %b b_in %b ctl %h want 00001 0 %h",
                     step, b_in, ctl, C_FETCH1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (step !== 5'b00010 || ctl !== C_FETCH2) begin
            n_fail++;
            $display("FAIL mid_after: step %b ctl %h want 00010 %h", step, ctl, C_FETCH2);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (alu_out !== 1'b0 && step !== 5'b10000) begin
                n_fail++;
                $display("FAIL mid_alu cyc=%0d: alu_out %b step %b want no alu_out outside T5",
                         c, alu_out, step);
            end
        end
        // Resynchronise to T1 for the next scenario.
        for (int c = 0; c < 8 && step !== 5'b00001; c++) @(negedge clk);
    endtask

    task automatic test_random();
        int bus_cnt;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            opcode = 4'($urandom_range(0, 14));
            cf     = 1'($urandom);
            zf     = 1'($urandom);
            #1;
            bus_cnt = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
            n_tests++;
            if (bus_cnt > 1 || (ram_in && ram_out)) begin
                n_fail++;
                $display("FAIL random_bus cyc=%0d: drivers %0d ram_in %b ram_out %b want <=1 and not both",
                         c, bus_cnt, ram_in, ram_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_instructions();
        test_reset_mid();
        test_instructions();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
